// File: rtl/matmat_seq.sv
// Sequential signed fixed-point N x N matrix multiplier with one shared MAC. Each product takes one clock.
// Defining MATMAT_SAT_EN makes the result narrowing saturate; otherwise it wraps.
module matmat_seq #(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_POS     = 8,
  parameter int MATRIX_SIZE = 3
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     matrix_a,
  input  logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     matrix_b,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0]     mul,
  output logic                                              busy
);

  localparam int W  = DATA_WIDTH;
  localparam int N  = MATRIX_SIZE;
  localparam int VW = N * N * W;
  localparam int AW = 2 * W + $clog2(N) + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t               state_q, state_d;
  logic [VW-1:0]        a_q, b_q, mul_q;
  logic [CW-1:0]        i_q, j_q, k_q;
  logic signed [AW-1:0] acc_q;

  logic signed [W-1:0]   a_el, b_el;
  logic signed [2*W-1:0] prod;
  logic signed [AW-1:0]  prod_ext, sum, shifted;
  logic                  last_k, last_j, last_i, accept;
  int                    a_idx, b_idx, m_idx;

  function automatic logic signed [W-1:0] narrow(input logic signed [AW-1:0] v);
`ifdef MATMAT_SAT_EN
    logic signed [AW-1:0] maxv;
    logic signed [AW-1:0] minv;
    maxv = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    minv = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
    if (v > maxv)      return {1'b0, {(W-1){1'b1}}};
    else if (v < minv) return {1'b1, {(W-1){1'b0}}};
    else               return W'(v);
`else
    return W'(v);
`endif
  endfunction

  assign a_idx = (int'(i_q) * N + int'(k_q)) * W;
  assign b_idx = (int'(k_q) * N + int'(j_q)) * W;
  assign m_idx = (int'(i_q) * N + int'(j_q)) * W;

  assign a_el     = a_q[a_idx +: W];
  assign b_el     = b_q[b_idx +: W];
  assign prod     = $signed({{W{a_el[W-1]}}, a_el}) * $signed({{W{b_el[W-1]}}, b_el});
  assign prod_ext = {{(AW-2*W){prod[2*W-1]}}, prod};
  assign sum      = acc_q + prod_ext;
  assign shifted  = sum >>> BIN_POS;

  assign last_k = (k_q == CW'(N - 1));
  assign last_j = (j_q == CW'(N - 1));
  assign last_i = (i_q == CW'(N - 1));

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign mul       = mul_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = COMPUTE;
      COMPUTE: if (last_k && last_j && last_i) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Loop order is k innermost, then j, then i; each (i,j) result is written when its last k is reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      mul_q <= '0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else if (accept) begin
      a_q   <= matrix_a;
      b_q   <= matrix_b;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
    end else if (state_q == COMPUTE) begin
      if (last_k) begin
        mul_q[m_idx +: W] <= narrow(shifted);
        acc_q <= '0;
        k_q   <= '0;
        if (last_j) begin
          j_q <= '0;
          i_q <= last_i ? '0 : i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end else begin
        acc_q <= sum;
        k_q   <= k_q + 1'b1;
      end
    end
  end

endmodule
